// File: rtl/calc_req_scheduler_if.sv
// ----------------------------------------------------------------------------
// calc_req_scheduler_if
// Dispatch/response bus between the request scheduler and the shared ALU.
//   master : scheduler side (drives alu_valid/cmd/tag/port/op1/op2,
//            receives alu_ready and the alu_rsp_* response strobe)
//   slave  : ALU side (mirror image of master)
// ----------------------------------------------------------------------------
interface calc_req_scheduler_if;
   logic        alu_valid;
   logic        alu_ready;
   logic [3:0]  alu_cmd;
   logic [1:0]  alu_tag;
   logic [1:0]  alu_port;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic        alu_rsp_valid;
   logic [1:0]  alu_rsp_port;
   logic [1:0]  alu_rsp_tag;
   logic [1:0]  alu_rsp_code;
   logic [31:0] alu_rsp_data;

   modport master (
      output alu_valid, alu_cmd, alu_tag, alu_port, alu_op1, alu_op2,
      input  alu_ready, alu_rsp_valid, alu_rsp_port, alu_rsp_tag,
             alu_rsp_code, alu_rsp_data
   );

   modport slave (
      input  alu_valid, alu_cmd, alu_tag, alu_port, alu_op1, alu_op2,
      output alu_ready, alu_rsp_valid, alu_rsp_port, alu_rsp_tag,
             alu_rsp_code, alu_rsp_data
   );
endinterface

// File: rtl/calc_req_scheduler.sv
// ----------------------------------------------------------------------------
// calc_req_scheduler
// Four-port request scheduler in front of the shared calculator ALU.
// Each port delivers a two-cycle request (cmd/tag/op1, then op2). Requests are
// classified (bad command or duplicate in-flight tag -> reject), buffered per
// port, arbitrated round-robin onto the ALU, and ALU responses are routed
// back to the issuing port. Reject entries retire straight to the port.
// Ports:
//   clk, reset           rising-edge clock, async active-low reset
//   req_cmd/tag/data_in  per-port request inputs
//   out_resp/data/tag    per-port registered response (one-cycle pulse)
//   ovf_err              sticky per-port FIFO overflow flags
//   alu                  dispatch/response bus (master side)
// ----------------------------------------------------------------------------
module calc_req_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req_cmd_in  [4],
   input  logic [1:0]  req_tag_in  [4],
   input  logic [31:0] req_data_in [4],
   output logic [1:0]  out_resp    [4],
   output logic [31:0] out_data    [4],
   output logic [1:0]  out_tag     [4],
   output logic [3:0]  ovf_err,
   calc_req_scheduler_if.master alu
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OP2  = 1'b1
   } cap_state_e;

   typedef struct packed {
      logic        reject;
      logic [3:0]  cmd;
      logic [1:0]  tag;
      logic [31:0] op1;
      logic [31:0] op2;
   } entry_t;

   localparam entry_t ENTRY_ZERO = '{reject: 1'b0, cmd: 4'd0, tag: 2'd0,
                                     op1: 32'd0, op2: 32'd0};

   // Accepted ALU opcodes: add, sub, shl, shr.
   function automatic logic is_valid_cmd(input logic [3:0] cmd);
      case (cmd)
         4'd1, 4'd2, 4'd5, 4'd6: is_valid_cmd = 1'b1;
         default:                is_valid_cmd = 1'b0;
      endcase
   endfunction

   // State registers and their next-state values
   cap_state_e  cap_state_q [4], cap_state_d [4];
   logic [3:0]  cap_cmd_q   [4], cap_cmd_d   [4];
   logic [1:0]  cap_tag_q   [4], cap_tag_d   [4];
   logic [31:0] cap_op1_q   [4], cap_op1_d   [4];
   entry_t      fifo_mem_q  [4][FIFO_DEPTH];
   entry_t      fifo_mem_d  [4][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [4], wr_ptr_d [4];
   logic [PTR_W-1:0] rd_ptr_q [4], rd_ptr_d [4];
   logic [CNT_W-1:0] count_q  [4], count_d  [4];
   logic [3:0]  bitmap_q   [4], bitmap_d   [4];
   logic [1:0]  out_resp_q [4], out_resp_d [4];
   logic [31:0] out_data_q [4], out_data_d [4];
   logic [1:0]  out_tag_q  [4], out_tag_d  [4];
   logic [3:0]  ovf_q, ovf_d;
   logic [1:0]  rr_q, rr_d;
   logic [1:0]  grant_q, grant_d;
   logic        lock_q, lock_d;

   // Combinational helpers
   entry_t      head_s  [4];
   entry_t      entry_s [4];
   logic [3:0]  head_vld_s;
   logic [3:0]  elig_s;
   logic [3:0]  rsp_hit_s;
   logic [3:0]  ret_s;
   logic [3:0]  pop_s;
   logic [3:0]  push_s;
   logic [3:0]  push_ok_s;
   logic        arb_found_s;
   logic [1:0]  arb_grant_s;
   logic [1:0]  grant_s;
   logic        alu_valid_s;
   logic        hs_s;

   // FIFO heads and round-robin pick; a stalled grant is held via lock_q
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         head_s[p]     = fifo_mem_q[p][rd_ptr_q[p]];
         head_vld_s[p] = (count_q[p] != CNT_W'(0));
         elig_s[p]     = head_vld_s[p] && !head_s[p].reject;
      end
      arb_found_s = 1'b0;
      arb_grant_s = 2'd0;
      // Search starts one past the last granted port.
      for (int i = 1; i <= 4; i++) begin
         if (!arb_found_s && elig_s[2'(rr_q + i[1:0])]) begin
            arb_found_s = 1'b1;
            arb_grant_s = 2'(rr_q + i[1:0]);
         end else begin
            arb_found_s = arb_found_s;
         end
      end
      // lock_q is only set while a valid grant is stalled, and the granted
      // head can only leave by handshake, so the held grant stays valid.
      if (lock_q) begin
         grant_s     = grant_q;
         alu_valid_s = 1'b1;
      end else begin
         grant_s     = arb_grant_s;
         alu_valid_s = arb_found_s;
      end
   end

   // Next-state logic: capture FSMs, classification, FIFOs, bitmaps, outputs
   always_comb begin
      hs_s    = alu_valid_s && alu.alu_ready;
      lock_d  = alu_valid_s && !alu.alu_ready;
      grant_d = grant_s;
      rr_d    = hs_s ? grant_s : rr_q;
      ovf_d   = ovf_q;
      for (int p = 0; p < 4; p++) begin
         rsp_hit_s[p] = alu.alu_rsp_valid && (alu.alu_rsp_port == 2'(p));
         // An ALU response owns the port's output this cycle; a reject waits.
         ret_s[p]     = head_vld_s[p] && head_s[p].reject && !rsp_hit_s[p];
         pop_s[p]     = (hs_s && (grant_s == 2'(p))) || ret_s[p];
         push_s[p]    = (cap_state_q[p] == ST_OP2);
         // Pop frees a slot before the push is judged against full.
         push_ok_s[p] = push_s[p] &&
                        ((count_q[p] != CNT_W'(FIFO_DEPTH)) || pop_s[p]);

         entry_s[p].reject = !is_valid_cmd(cap_cmd_q[p]) ||
                             bitmap_q[p][cap_tag_q[p]];
         entry_s[p].cmd    = cap_cmd_q[p];
         entry_s[p].tag    = cap_tag_q[p];
         entry_s[p].op1    = cap_op1_q[p];
         entry_s[p].op2    = req_data_in[p];

         cap_state_d[p] = cap_state_q[p];
         cap_cmd_d[p]   = cap_cmd_q[p];
         cap_tag_d[p]   = cap_tag_q[p];
         cap_op1_d[p]   = cap_op1_q[p];
         case (cap_state_q[p])
            ST_IDLE: begin
               if (req_cmd_in[p] != 4'd0) begin
                  cap_state_d[p] = ST_OP2;
                  cap_cmd_d[p]   = req_cmd_in[p];
                  cap_tag_d[p]   = req_tag_in[p];
                  cap_op1_d[p]   = req_data_in[p];
               end else begin
                  cap_state_d[p] = ST_IDLE;
               end
            end
            ST_OP2:  cap_state_d[p] = ST_IDLE;
            default: cap_state_d[p] = ST_IDLE;
         endcase

         for (int e = 0; e < FIFO_DEPTH; e++) begin
            fifo_mem_d[p][e] = fifo_mem_q[p][e];
         end
         if (push_ok_s[p]) begin
            fifo_mem_d[p][wr_ptr_q[p]] = entry_s[p];
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(1);
         end else begin
            wr_ptr_d[p] = wr_ptr_q[p];
         end
         if (pop_s[p]) begin
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(1);
         end else begin
            rd_ptr_d[p] = rd_ptr_q[p];
         end
         count_d[p] = count_q[p] + CNT_W'(push_ok_s[p]) - CNT_W'(pop_s[p]);

         if (push_s[p] && !push_ok_s[p]) begin
            ovf_d[p] = 1'b1;
         end else begin
            ovf_d[p] = ovf_q[p];
         end

         bitmap_d[p] = bitmap_q[p];
         if (rsp_hit_s[p]) begin
            bitmap_d[p][alu.alu_rsp_tag] = 1'b0;
         end else begin
            bitmap_d[p] = bitmap_q[p];
         end
         if (push_ok_s[p] && !entry_s[p].reject) begin
            bitmap_d[p][cap_tag_q[p]] = 1'b1;
         end else begin
            bitmap_d[p] = bitmap_d[p];
         end

         if (rsp_hit_s[p]) begin
            out_resp_d[p] = alu.alu_rsp_code;
            out_data_d[p] = alu.alu_rsp_data;
            out_tag_d[p]  = alu.alu_rsp_tag;
         end else if (ret_s[p]) begin
            out_resp_d[p] = 2'b10;
            out_data_d[p] = 32'd0;
            out_tag_d[p]  = head_s[p].tag;
         end else begin
            out_resp_d[p] = 2'b00;
            out_data_d[p] = 32'd0;
            out_tag_d[p]  = 2'b00;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 4; p++) begin
            cap_state_q[p] <= ST_IDLE;
            cap_cmd_q[p]   <= 4'd0;
            cap_tag_q[p]   <= 2'd0;
            cap_op1_q[p]   <= 32'd0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               fifo_mem_q[p][e] <= ENTRY_ZERO;
            end
            wr_ptr_q[p]   <= PTR_W'(0);
            rd_ptr_q[p]   <= PTR_W'(0);
            count_q[p]    <= CNT_W'(0);
            bitmap_q[p]   <= 4'd0;
            out_resp_q[p] <= 2'b00;
            out_data_q[p] <= 32'd0;
            out_tag_q[p]  <= 2'b00;
         end
         ovf_q   <= 4'd0;
         rr_q    <= 2'd3;
         grant_q <= 2'd0;
         lock_q  <= 1'b0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            cap_state_q[p] <= cap_state_d[p];
            cap_cmd_q[p]   <= cap_cmd_d[p];
            cap_tag_q[p]   <= cap_tag_d[p];
            cap_op1_q[p]   <= cap_op1_d[p];
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               fifo_mem_q[p][e] <= fifo_mem_d[p][e];
            end
            wr_ptr_q[p]   <= wr_ptr_d[p];
            rd_ptr_q[p]   <= rd_ptr_d[p];
            count_q[p]    <= count_d[p];
            bitmap_q[p]   <= bitmap_d[p];
            out_resp_q[p] <= out_resp_d[p];
            out_data_q[p] <= out_data_d[p];
            out_tag_q[p]  <= out_tag_d[p];
         end
         ovf_q   <= ovf_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         lock_q  <= lock_d;
      end
   end

   // Dispatch fields come straight from the granted (registered) FIFO head.
   assign alu.alu_valid = alu_valid_s;
   assign alu.alu_port  = alu_valid_s ? grant_s : 2'd0;
   assign alu.alu_cmd   = alu_valid_s ? head_s[grant_s].cmd : 4'd0;
   assign alu.alu_tag   = alu_valid_s ? head_s[grant_s].tag : 2'd0;
   assign alu.alu_op1   = alu_valid_s ? head_s[grant_s].op1 : 32'd0;
   assign alu.alu_op2   = alu_valid_s ? head_s[grant_s].op2 : 32'd0;

   assign out_resp = out_resp_q;
   assign out_data = out_data_q;
   assign out_tag  = out_tag_q;
   assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_calc_req_scheduler.sv
// ----------------------------------------------------------------------------
// tb_calc_req_scheduler
// Directed bench for calc_req_scheduler. The bench plays the ALU through the
// interface; inputs change 1 time unit after the rising edge and outputs are
// sampled at that same point.
// ----------------------------------------------------------------------------
module tb_calc_req_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_cmd_in  [4];
   logic [1:0]  req_tag_in  [4];
   logic [31:0] req_data_in [4];
   logic [1:0]  out_resp    [4];
   logic [31:0] out_data    [4];
   logic [1:0]  out_tag     [4];
   logic [3:0]  ovf_err;
   int          n_checks = 0;
   int          n_fail   = 0;

   calc_req_scheduler_if alu_if ();

   calc_req_scheduler #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_tag_in  (req_tag_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .ovf_err     (ovf_err),
      .alu         (alu_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < 4; p++) begin
         req_cmd_in[p]  = 4'd0;
         req_tag_in[p]  = 2'd0;
         req_data_in[p] = 32'd0;
      end
      alu_if.alu_rsp_valid = 1'b0;
      alu_if.alu_rsp_port  = 2'd0;
      alu_if.alu_rsp_tag   = 2'd0;
      alu_if.alu_rsp_code  = 2'd0;
      alu_if.alu_rsp_data  = 32'd0;
   endtask

   task automatic req(input int p, input logic [3:0] cmd,
                      input logic [1:0] tag, input logic [31:0] data);
      req_cmd_in[p]  = cmd;
      req_tag_in[p]  = tag;
      req_data_in[p] = data;
   endtask

   task automatic rsp(input logic [1:0] port, input logic [1:0] tag,
                      input logic [1:0] code, input logic [31:0] data);
      alu_if.alu_rsp_valid = 1'b1;
      alu_if.alu_rsp_port  = port;
      alu_if.alu_rsp_tag   = tag;
      alu_if.alu_rsp_code  = code;
      alu_if.alu_rsp_data  = data;
   endtask

   task automatic check_alu(input string tag, input logic [1:0] port,
                            input logic [1:0] atag, input logic [3:0] cmd,
                            input logic [31:0] op1, input logic [31:0] op2);
      check({tag, "_valid"}, alu_if.alu_valid, 32'd1);
      check({tag, "_port"},  alu_if.alu_port,  port);
      check({tag, "_tag"},   alu_if.alu_tag,   atag);
      check({tag, "_cmd"},   alu_if.alu_cmd,   cmd);
      check({tag, "_op1"},   alu_if.alu_op1,   op1);
      check({tag, "_op2"},   alu_if.alu_op2,   op2);
   endtask

   task automatic check_resp(input string tag, input int p,
                             input logic [1:0] resp, input logic [1:0] rtag,
                             input logic [31:0] data);
      check({tag, "_resp"}, out_resp[p], resp);
      check({tag, "_tag"},  out_tag[p],  rtag);
      check({tag, "_data"}, out_data[p], data);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      alu_if.alu_ready = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_alu_valid", alu_if.alu_valid, 32'd0);
      check("rst_alu_cmd",   alu_if.alu_cmd,   32'd0);
      check("rst_alu_op1",   alu_if.alu_op1,   32'd0);
      check("rst_ovf",       ovf_err,          32'd0);
      for (int p = 0; p < 4; p++) begin
         check_resp("rst_out", p, 2'b00, 2'd0, 32'd0);
      end
      reset = 1'b1;
      alu_if.alu_ready = 1'b1;

      // Single add on port 0
      req(0, 4'd1, 2'd2, 32'd5);
      tick();                                   // N+1
      req(0, 4'd0, 2'd0, 32'd7);
      check("t1_n1_valid", alu_if.alu_valid, 32'd0);
      tick();                                   // N+2
      req(0, 4'd0, 2'd0, 32'd0);
      check_alu("t1_disp", 2'd0, 2'd2, 4'd1, 32'd5, 32'd7);
      tick();                                   // N+3
      check("t1_n3_valid", alu_if.alu_valid, 32'd0);
      rsp(2'd0, 2'd2, 2'b01, 32'd12);
      tick();
      idle_inputs();
      check_resp("t1_rsp", 0, 2'b01, 2'd2, 32'd12);
      tick();
      check_resp("t1_rsp_end", 0, 2'b00, 2'd0, 32'd0);

      // Invalid command on port 2; command held during OP2 is ignored
      req(2, 4'd3, 2'd1, 32'hAA);
      tick();
      req_data_in[2] = 32'hBB;
      tick();                                   // N+2
      idle_inputs();
      check("t2_no_disp", alu_if.alu_valid, 32'd0);
      tick();                                   // N+3
      check_resp("t2_rej", 2, 2'b10, 2'd1, 32'd0);
      check("t2_n3_valid", alu_if.alu_valid, 32'd0);
      tick();
      check("t2_single", out_resp[2], 32'd0);

      // Duplicate tag on port 1, then reuse after response
      req(1, 4'd1, 2'd0, 32'd10);
      tick();
      req(1, 4'd0, 2'd0, 32'd3);
      tick();                                   // A+2
      req(1, 4'd2, 2'd0, 32'd1);
      check_alu("t3_first", 2'd1, 2'd0, 4'd1, 32'd10, 32'd3);
      tick();                                   // A+3
      req(1, 4'd0, 2'd0, 32'd1);
      tick();                                   // A+4
      idle_inputs();
      check("t3_dup_no_disp", alu_if.alu_valid, 32'd0);
      tick();                                   // A+5
      check_resp("t3_dup_rej", 1, 2'b10, 2'd0, 32'd0);
      rsp(2'd1, 2'd0, 2'b01, 32'd13);
      tick();                                   // A+6
      idle_inputs();
      check_resp("t3_first_rsp", 1, 2'b01, 2'd0, 32'd13);
      req(1, 4'd6, 2'd0, 32'd8);
      tick();
      req(1, 4'd0, 2'd0, 32'd1);
      tick();                                   // A+8
      idle_inputs();
      check_alu("t3_reuse", 2'd1, 2'd0, 4'd6, 32'd8, 32'd1);
      tick();                                   // A+9
      // OP2 lands in the same cycle as the clearing response -> reject
      req(1, 4'd1, 2'd0, 32'd1);
      tick();                                   // A+10
      req(1, 4'd0, 2'd0, 32'd2);
      rsp(2'd1, 2'd0, 2'b01, 32'd4);
      tick();                                   // A+11
      idle_inputs();
      check_resp("t3_shr_rsp", 1, 2'b01, 2'd0, 32'd4);
      check("t3_edge_no_disp", alu_if.alu_valid, 32'd0);
      tick();                                   // A+12
      check_resp("t3_edge_rej", 1, 2'b10, 2'd0, 32'd0);
      tick();
      check("t3_end", out_resp[1], 32'd0);

      // Same-port collision: ALU response beats reject retirement
      req(2, 4'd7, 2'd3, 32'd1);
      tick();
      req(2, 4'd0, 2'd0, 32'd2);
      tick();                                   // C+2
      idle_inputs();
      rsp(2'd2, 2'd1, 2'b01, 32'd99);
      tick();                                   // C+3
      idle_inputs();
      check_resp("t_coll_rsp", 2, 2'b01, 2'd1, 32'd99);
      tick();                                   // C+4
      check_resp("t_coll_rej", 2, 2'b10, 2'd3, 32'd0);
      tick();
      check("t_coll_end", out_resp[2], 32'd0);

      // All four ports, 3-cycle stall, round-robin from port 0
      do_reset();
      alu_if.alu_ready = 1'b0;
      for (int p = 0; p < 4; p++) req(p, 4'd1, 2'(p), 32'(100 + p));
      tick();
      for (int p = 0; p < 4; p++) req(p, 4'd0, 2'd0, 32'(200 + p));
      tick();                                   // D+2
      idle_inputs();
      check_alu("t4_stall0", 2'd0, 2'd0, 4'd1, 32'd100, 32'd200);
      tick();
      check_alu("t4_stall1", 2'd0, 2'd0, 4'd1, 32'd100, 32'd200);
      tick();                                   // D+4
      check_alu("t4_stall2", 2'd0, 2'd0, 4'd1, 32'd100, 32'd200);
      alu_if.alu_ready = 1'b1;
      tick();
      check_alu("t4_p1", 2'd1, 2'd1, 4'd1, 32'd101, 32'd201);
      tick();
      check_alu("t4_p2", 2'd2, 2'd2, 4'd1, 32'd102, 32'd202);
      tick();
      check_alu("t4_p3", 2'd3, 2'd3, 4'd1, 32'd103, 32'd203);
      tick();
      check("t4_drained", alu_if.alu_valid, 32'd0);

      // Port 3 overflow: fifth request dropped
      do_reset();
      alu_if.alu_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         req(3, 4'd1, 2'(k), 32'(300 + k));
         tick();
         req(3, 4'd0, 2'd0, 32'(400 + k));
         tick();
      end
      idle_inputs();
      check("t5_ovf", ovf_err, 32'h8);
      check("t5_no_resp", out_resp[3], 32'd0);
      alu_if.alu_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_alu("t5_disp", 2'd3, 2'(k), 4'd1, 32'(300 + k), 32'(400 + k));
         tick();
      end
      check("t5_drained", alu_if.alu_valid, 32'd0);
      check("t5_ovf_sticky", ovf_err, 32'h8);

      // Reset asserted mid-stall with entries queued and a response pending
      alu_if.alu_ready = 1'b0;
      req(0, 4'd1, 2'd0, 32'd11);
      req(1, 4'd2, 2'd1, 32'd22);
      tick();
      req(0, 4'd0, 2'd0, 32'd1);
      req(1, 4'd0, 2'd0, 32'd2);
      tick();
      idle_inputs();
      check("t6_pre_valid", alu_if.alu_valid, 32'd1);
      rsp(2'd2, 2'd0, 2'b01, 32'd55);
      tick();
      idle_inputs();
      check("t6_pre_resp", out_resp[2], 32'd1);
      #3;
      reset = 1'b0;
      #1;
      check("t6_rst_valid", alu_if.alu_valid, 32'd0);
      check("t6_rst_cmd",   alu_if.alu_cmd,   32'd0);
      check("t6_rst_ovf",   ovf_err,          32'd0);
      check_resp("t6_rst_out", 2, 2'b00, 2'd0, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      alu_if.alu_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check("t6_post_valid", alu_if.alu_valid, 32'd0);
         for (int p = 0; p < 4; p++) check("t6_post_resp", out_resp[p], 32'd0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
